// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/flush sequencer.
package hazard_ctrl_pkg;

    localparam int unsigned CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the optional hazard performance counters.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use bubble insertion and taken-branch flush sequencing for the 5-stage core.
// Optional stall/flush perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             Branch_Taken,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic [1:0]       hazard_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    if ((STALL_CYCLES == 0) || (STALL_CYCLES > 15) ||
        (FLUSH_CYCLES == 0) || (FLUSH_CYCLES > 15) || (CNT_W == 0)) begin : g_bad_params
        $error("hazard_ctrl_unit: parameter out of legal range");
    end

    localparam hz_state_e              STALL_NEXT = (STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
    localparam hz_state_e              FLUSH_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    localparam logic [CNT_BITS-1:0]    STALL_CNT  = CNT_BITS'(STALL_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]    FLUSH_CNT  = CNT_BITS'(FLUSH_CYCLES - 1);

    hz_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    // Next state and outputs; reset and branch override whatever the state asks for.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (reset) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (Branch_Taken) begin
            state_d      = FLUSH_NEXT;
            cnt_d        = FLUSH_CNT;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else begin
            case (state_q)
                ST_STALL: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    if (cnt_q <= CNT_BITS'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end
                end
                ST_FLUSH: begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    if (cnt_q <= CNT_BITS'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        state_d     = STALL_NEXT;
                        cnt_d       = STALL_CNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hazard_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~IF_ID_Write),
        .count (stall_count)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (Branch_Taken),
        .count (flush_count)
    );
`endif

endmodule
